add_bcd: RTL and testbench
==========================

Name: add_bcd

Overview:
Producer side of the PS/2 scan-code byte stream (Set 2). Converts key events (code, extended flag, make/break flag) into byte sequences: optional E0 prefix, optional F0 break prefix, then the code byte. Optional typematic repeat of the last pressed key. Sits between the key-event source (matrix scanner or test stimulus) and the PS/2 device-side serializer. Its scode/scode_en output feeds the existing make/break filter directly.

Parameters:
GAP_CYC, 2, idle cycles between successive scode_en pulses and after the last byte of a sequence (0 = back-to-back)
TYPEMATIC_EN, 1, 1 enables auto-repeat of the last pressed key
DELAY_CYC, 20, IDLE cycles before the first repeat (must be >= 1)
RATE_CYC, 10, IDLE cycles between later repeats (must be >= 1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
key_code  in  8  key scan code, without prefixes
key_ext  in  1  1 = extended key, E0 prefix required
key_brk  in  1  1 = release (break), 0 = press (make)
key_en  in  1  event valid; accepted when key_en && key_rdy
key_rdy  out  1  high only in state S_IDLE
err_clr  in  1  clears err sticky bits
scode  out  8  output byte, held until the next pulse
scode_en  out  1  one-cycle strobe, new byte valid on scode
err  out  8  sticky errors: bit0 overrun, bit1 illegal code, bits7:2 = 0

Behaviour:
- Reset (async, rst_n low): state S_IDLE; scode=8'h00, scode_en=0, err=0, key_rdy=1; repeat disarmed, counters=0. Reset mid-sequence abandons the remaining bytes with no further output.
- States: S_IDLE, S_EXT, S_BRK, S_CODE, S_GAP. Each emit state (S_EXT/S_BRK/S_CODE) lasts exactly 1 cycle. scode/scode_en are registered.
- Acceptance at edge t: latch code/ext/brk. The first byte's scode_en is high in the cycle after edge t (latency 1).
- Byte order: S_EXT (E0) if ext, then S_BRK (F0) if brk, then S_CODE (code). Only the needed states are entered.
- Between emit states, and after S_CODE, spend GAP_CYC cycles in S_GAP. Pulse spacing = GAP_CYC+1 cycles. key_rdy returns high GAP_CYC+1 cycles after the S_CODE pulse. With GAP_CYC=0, S_GAP is skipped.
- Illegal code: key_code equal to 8'hF0 or 8'hE0 is accepted (consumed) but produces no output. It sets err[1] and leaves the state in S_IDLE.
- Overrun: key_en high while key_rdy is low sets err[0]. The event is dropped.
- err bits are sticky and cleared by err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- Typematic (TYPEMATIC_EN=1):
  - Armed registers rep_code, rep_ext, rep_vld.
  - An accepted legal make loads the armed registers, sets rep_vld, and zeros the repeat counter.
  - An accepted break with matching code and ext clears rep_vld. A break for a different key leaves the repeat armed and preserves the counter.
  - The counter increments only in S_IDLE with rep_vld=1.
  - When the counter reaches DELAY_CYC (first repeat) or RATE_CYC (later repeats), emit the make sequence [E0] code with no F0, via the same states and gaps. Zero the counter and switch to the RATE phase.
  - If key_en is accepted in the same cycle the repeat would fire, the key event wins and the repeat is not emitted.
  - key_rdy is low during a repeat sequence.
- TYPEMATIC_EN=0: the repeat logic is tied off and never fires.
- scode_en is never high in two consecutive cycles unless GAP_CYC=0.

Decomposition:
- Shared package ps2_pkg holds:
  - LP_BREAK_CODE = 8'hF0 and LP_EXT_CODE = 8'hE0, shared with the break-code remover.
  - The state enum type.
  - The err bit index constants.
- Sub-module add_bcd_tm: typematic timer containing the armed registers and counter. Outputs rep_fire, rep_code, rep_ext. Width is $clog2(max(DELAY_CYC,RATE_CYC)+1).

Test Plan:
(All scenarios use GAP_CYC=2, DELAY_CYC=20, RATE_CYC=10.)
- Make 8'h1C, ext=0, accepted at cycle 0 -> 1C pulse at cycle 1; key_rdy high at cycle 4.
- Break 8'h1C, ext=0 -> F0 pulse at cycle 1, 1C pulse at cycle 4; key_rdy high at cycle 7; downstream remover outputs nothing.
- Extended break 8'h75, ext=1 -> E0 pulse at 1, F0 at 4, 75 at 7; key_rdy high at cycle 10.
- Overrun and illegal code:
  - key_en pulsed at cycle 2 during a sequence -> err=8'h01, no extra bytes.
  - Code 8'hF0 submitted -> err bit1 set, no output.
  - err_clr -> err=8'h00.
- Typematic:
  - Make 8'h1C, then idle -> first repeat 1C pulse 21 cycles after key_rdy returns, then every 14 cycles (10 idle + 4 sequence).
  - Break 8'h2A -> repeats continue.
  - Break 8'h1C -> F0,1C emitted, then no further pulses.
- Reset asserted between E0 and F0 of an extended break -> scode=00, scode_en=0, key_rdy=1, no F0 after release; a fresh make emits normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 Set 2 constants, state type and error bit indices
package ps2_pkg;

  localparam logic [7:0] LP_BREAK_CODE = 8'hF0;
  localparam logic [7:0] LP_EXT_CODE   = 8'hE0;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_ILLEGAL = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_CODE,
    S_GAP
  } state_t;

  // Prefix bytes cannot be sent as key codes; the receiver would misparse them
  function automatic logic is_prefix(input logic [7:0] code);
    return (code == LP_BREAK_CODE) || (code == LP_EXT_CODE);
  endfunction

endpackage

// File: rtl/add_bcd_if.sv
// rtl/add_bcd_if.sv - key event input and scan-code byte output bundle
interface add_bcd_if;

  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_en;
  logic       key_rdy;
  logic [7:0] scode;
  logic       scode_en;

  // Key-event source side: offers events, sees readiness and the byte stream
  modport master (
    output key_code, key_ext, key_brk, key_en,
    input  key_rdy, scode, scode_en
  );

  // Scan-code producer side
  modport slave (
    input  key_code, key_ext, key_brk, key_en,
    output key_rdy, scode, scode_en
  );

endinterface

// File: rtl/add_bcd_tm.sv
// rtl/add_bcd_tm.sv - typematic timer holding the armed key and repeat counter
module add_bcd_tm #(
  parameter int TYPEMATIC_EN = 1,
  parameter int DELAY_CYC    = 20,
  parameter int RATE_CYC     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idle,
  input  logic       accept,
  input  logic       make_ev,
  input  logic       brk_ev,
  input  logic [7:0] ev_code,
  input  logic       ev_ext,
  output logic       rep_fire,
  output logic [7:0] rep_code,
  output logic       rep_ext
);

  localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic             rep_vld;
  logic             rate_ph;
  logic             at_lim;
  logic             brk_match;

  assign lim       = rate_ph ? CNT_W'(RATE_CYC) : CNT_W'(DELAY_CYC);
  assign at_lim    = (cnt == lim);
  assign brk_match = brk_ev && rep_vld && (ev_code == rep_code) && (ev_ext == rep_ext);

  // A key event accepted in the same idle cycle always beats the repeat
  assign rep_fire  = (TYPEMATIC_EN != 0) && rep_vld && idle && !accept && at_lim;

  // Arm on make, disarm on matching break, count idle cycles toward the next repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rep_vld  <= 1'b0;
      rate_ph  <= 1'b0;
      rep_code <= 8'h00;
      rep_ext  <= 1'b0;
    end else if (make_ev) begin
      rep_code <= ev_code;
      rep_ext  <= ev_ext;
      rep_vld  <= 1'b1;
      rate_ph  <= 1'b0;
      cnt      <= '0;
    end else if (brk_match) begin
      rep_vld  <= 1'b0;
      rate_ph  <= 1'b0;
      cnt      <= '0;
    end else if (rep_fire) begin
      rate_ph  <= 1'b1;
      cnt      <= '0;
    end else if (rep_vld && idle && !accept && !at_lim) begin
      cnt      <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/add_bcd.sv
// rtl/add_bcd.sv - PS/2 Set 2 scan-code byte sequencer with typematic repeat
module add_bcd
  import ps2_pkg::*;
#(
  parameter int GAP_CYC      = 2,
  parameter int TYPEMATIC_EN = 1,
  parameter int DELAY_CYC    = 20,
  parameter int RATE_CYC     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  add_bcd_if.slave   bus,
  input  logic       err_clr,
  output logic [7:0] err
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t           state;
  state_t           state_nxt;
  state_t           pend;
  state_t           pend_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_last;

  logic [7:0] code_q;
  logic       ext_q;
  logic       brk_q;
  logic [7:0] seq_code;
  logic       seq_ext;
  logic       seq_brk;

  logic       key_rdy;
  logic       accept;
  logic       illegal;
  logic       start_key;
  logic       overrun;

  logic       rep_fire;
  logic [7:0] rep_code;
  logic       rep_ext;

  logic [7:0] scode_d;
  logic       scode_en_d;
  logic [7:0] scode_q;
  logic       scode_en_q;
  logic [7:0] err_nxt;

  assign key_rdy     = (state == S_IDLE);
  assign bus.key_rdy = key_rdy;
  assign bus.scode    = scode_q;
  assign bus.scode_en = scode_en_q;

  assign accept    = bus.key_en && key_rdy;
  assign illegal   = accept && is_prefix(bus.key_code);
  assign start_key = accept && !illegal;
  assign overrun   = bus.key_en && !key_rdy;
  assign gap_last  = (gap_cnt == GAP_W'(GAP_CYC - 1));

  add_bcd_tm #(
    .TYPEMATIC_EN (TYPEMATIC_EN),
    .DELAY_CYC    (DELAY_CYC),
    .RATE_CYC     (RATE_CYC)
  ) u_tm (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (key_rdy),
    .accept   (accept),
    .make_ev  (start_key && !bus.key_brk),
    .brk_ev   (start_key && bus.key_brk),
    .ev_code  (bus.key_code),
    .ev_ext   (bus.key_ext),
    .rep_fire (rep_fire),
    .rep_code (rep_code),
    .rep_ext  (rep_ext)
  );

  // Emit state that follows the current one within a sequence
  function automatic state_t after_emit(input state_t s, input logic brk);
    case (s)
      S_EXT:   return brk ? S_BRK : S_CODE;
      S_BRK:   return S_CODE;
      default: return S_IDLE;
    endcase
  endfunction

  // State register and latched sequence contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pend   <= S_IDLE;
      code_q <= 8'h00;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      code_q <= seq_code;
      ext_q  <= seq_ext;
      brk_q  <= seq_brk;
    end
  end

  // Next state: pick sequence source in idle, walk emit states with gaps between
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    seq_code  = code_q;
    seq_ext   = ext_q;
    seq_brk   = brk_q;
    if (state == S_IDLE) begin
      if (start_key) begin
        seq_code = bus.key_code;
        seq_ext  = bus.key_ext;
        seq_brk  = bus.key_brk;
      end else if (rep_fire) begin
        seq_code = rep_code;
        seq_ext  = rep_ext;
        seq_brk  = 1'b0;
      end
    end
    case (state)
      S_IDLE: begin
        if (start_key || rep_fire) begin
          state_nxt = seq_ext ? S_EXT : (seq_brk ? S_BRK : S_CODE);
        end
      end
      S_EXT, S_BRK, S_CODE: begin
        if (GAP_CYC == 0) begin
          state_nxt = after_emit(state, brk_q);
        end else begin
          state_nxt = S_GAP;
          pend_nxt  = after_emit(state, brk_q);
        end
      end
      S_GAP: begin
        if (gap_last) state_nxt = pend;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output byte for the state about to be entered, registered below
  always_comb begin
    scode_d    = seq_code;
    scode_en_d = 1'b0;
    case (state_nxt)
      S_EXT: begin
        scode_d    = LP_EXT_CODE;
        scode_en_d = 1'b1;
      end
      S_BRK: begin
        scode_d    = LP_BREAK_CODE;
        scode_en_d = 1'b1;
      end
      S_CODE: begin
        scode_d    = seq_code;
        scode_en_d = 1'b1;
      end
      default: begin
        scode_d    = seq_code;
        scode_en_d = 1'b0;
      end
    endcase
  end

  // Gap counter runs only while staying in S_GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state == S_GAP && state_nxt == S_GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // Registered byte strobe; the byte itself holds until the next strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scode_q    <= 8'h00;
      scode_en_q <= 1'b0;
    end else begin
      scode_en_q <= scode_en_d;
      if (scode_en_d) scode_q <= scode_d;
    end
  end

  // Sticky error bits; a new error in the clearing cycle still lands
  always_comb begin
    err_nxt = err_clr ? 8'h00 : err;
    if (overrun) err_nxt[ERR_OVERRUN] = 1'b1;
    if (illegal) err_nxt[ERR_ILLEGAL] = 1'b1;
  end

  // Error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 8'h00;
    else        err <= err_nxt;
  end

endmodule

// File: tb/tb_add_bcd.sv
// tb/tb_add_bcd.sv - self-checking bench for the PS/2 scan-code sequencer
module tb_add_bcd;

  localparam int GAP = 2;
  localparam int GP  = GAP + 1;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic [7:0] err;
  int         cyc;
  int         total;
  int         bad;
  int         b2b_cnt;
  logic       prev_en;
  logic [7:0] pq[$];
  int         cq[$];
  logic [7:0] exp_q[$];
  vec_t       vt[8];

  add_bcd_if bus();

  add_bcd #(
    .GAP_CYC      (GAP),
    .TYPEMATIC_EN (1),
    .DELAY_CYC    (20),
    .RATE_CYC     (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_clr (err_clr),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    prev_en = 1'b0;
    b2b_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus.scode_en) begin
      pq.push_back(bus.scode);
      cq.push_back(cyc);
      if (prev_en) b2b_cnt = b2b_cnt + 1;
    end
    prev_en = bus.scode_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] c, input logic e, input logic b,
                              input int n, input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] x2);
    vec_t v;
    v.code = c; v.ext = e; v.brk = b; v.n = n; v.b0 = x0; v.b1 = x1; v.b2 = x2;
    return v;
  endfunction

  function automatic logic prefix(input logic [7:0] c);
    return (c == 8'hF0) || (c == 8'hE0);
  endfunction

  // Reference byte stream for one key event, straight from the Set 2 rules
  task automatic model_push(input logic [7:0] c, input logic e, input logic b);
    if (!prefix(c)) begin
      if (e) exp_q.push_back(8'hE0);
      if (b) exp_q.push_back(8'hF0);
      exp_q.push_back(c);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one event once ready; returns the acceptance interval and queue mark
  task automatic send(input logic [7:0] c, input logic e, input logic b,
                      output int acc, output int base);
    int w;
    w = 0;
    while (!bus.key_rdy && w < 200) begin
      @(posedge clk); #1; w++;
    end
    chk("rdy_wait", {31'd0, bus.key_rdy}, 32'd1);
    bus.key_code = c;
    bus.key_ext  = e;
    bus.key_brk  = b;
    bus.key_en   = 1'b1;
    @(posedge clk); #1;
    acc  = cyc;
    base = pq.size();
    bus.key_en = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int acc, base, rbad;
    logic [7:0] eb [3];
    eb[0] = v.b0; eb[1] = v.b1; eb[2] = v.b2;
    send(v.code, v.ext, v.brk, acc, base);
    rbad = 0;
    for (int k = 0; k <= v.n * GP + 1; k++) begin
      @(negedge clk);
      if (bus.key_rdy !== (cyc >= acc + v.n * GP)) rbad++;
    end
    @(posedge clk); #1;
    chk({nm, "_rdy"}, rbad, 0);
    chk({nm, "_cnt"}, pq.size() - base, v.n);
    for (int i = 0; i < v.n && base + i < pq.size(); i++) begin
      chk({nm, "_byte"}, pq[base + i], eb[i]);
      chk({nm, "_cyc"}, cq[base + i] - acc, i * GP);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, base, n_rep, b2, n_ill;
    logic [7:0] c;
    logic e, b;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; err_clr = 1'b0;
    bus.key_code = 8'h00; bus.key_ext = 1'b0; bus.key_brk = 1'b0; bus.key_en = 1'b0;

    vt[0] = mk(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 8'h00, 8'h00);
    vt[1] = mk(8'h1C, 1'b0, 1'b1, 2, 8'hF0, 8'h1C, 8'h00);
    vt[2] = mk(8'h75, 1'b1, 1'b0, 2, 8'hE0, 8'h75, 8'h00);
    vt[3] = mk(8'h75, 1'b1, 1'b1, 3, 8'hE0, 8'hF0, 8'h75);
    vt[4] = mk(8'hF0, 1'b0, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    vt[5] = mk(8'h00, 1'b0, 1'b0, 1, 8'h00, 8'h00, 8'h00);
    vt[6] = mk(8'h00, 1'b0, 1'b1, 2, 8'hF0, 8'h00, 8'h00);
    vt[7] = mk(8'hE0, 1'b1, 1'b1, 0, 8'h00, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scode", bus.scode, 8'h00);
    chk("rst_scode_en", {31'd0, bus.scode_en}, 32'd0);
    chk("rst_err", err, 8'h00);
    chk("rst_key_rdy", {31'd0, bus.key_rdy}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);
    chk("tbl_err", err, 8'h02);

    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    chk("clr_err", err, 8'h00);

    // Overrun during an extended break sequence
    send(8'h75, 1'b1, 1'b1, acc, base);
    cycles(1);
    bus.key_code = 8'h33; bus.key_en = 1'b1;
    cycles(1);
    bus.key_en = 1'b0;
    cycles(12);
    chk("ovr_err", err, 8'h01);
    chk("ovr_cnt", pq.size() - base, 3);
    if (pq.size() - base == 3) begin
      chk("ovr_b0", pq[base], 8'hE0);
      chk("ovr_b1", pq[base + 1], 8'hF0);
      chk("ovr_b2", pq[base + 2], 8'h75);
    end

    send(8'hF0, 1'b0, 1'b0, acc, base);
    cycles(3);
    chk("ill_err", err, 8'h03);
    chk("ill_cnt", pq.size() - base, 0);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    chk("clr2_err", err, 8'h00);

    err_clr = 1'b1;
    send(8'hE0, 1'b0, 1'b0, acc, base);
    err_clr = 1'b0;
    chk("set_wins", err, 8'h02);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;

    // Typematic: delay, rate, foreign break, own break
    do_reset();
    send(8'h1C, 1'b0, 1'b0, acc, base);
    cycles(60);
    chk("tm_cnt", pq.size() - base, 4);
    if (pq.size() - base == 4) begin
      chk("tm_c0", cq[base] - acc, 0);
      chk("tm_c1", cq[base + 1] - acc, 24);
      chk("tm_c2", cq[base + 2] - acc, 38);
      chk("tm_c3", cq[base + 3] - acc, 52);
      for (int i = 0; i < 4; i++) chk("tm_byte", pq[base + i], 8'h1C);
    end

    send(8'h2A, 1'b0, 1'b1, acc, base);
    cycles(40);
    n_rep = 0;
    chk("tm_oth_ge2", {31'd0, (pq.size() - base) >= 2}, 32'd1);
    if (pq.size() - base >= 2) begin
      chk("tm_oth_f0", pq[base], 8'hF0);
      chk("tm_oth_2a", pq[base + 1], 8'h2A);
      for (int i = base + 2; i < pq.size(); i++) if (pq[i] == 8'h1C) n_rep++;
      chk("tm_oth_rep", n_rep, pq.size() - base - 2);
    end
    chk("tm_continue", {31'd0, n_rep >= 1}, 32'd1);

    send(8'h1C, 1'b0, 1'b1, acc, base);
    cycles(60);
    chk("tm_stop_cnt", pq.size() - base, 2);
    if (pq.size() - base == 2) begin
      chk("tm_stop_b0", pq[base], 8'hF0);
      chk("tm_stop_b1", pq[base + 1], 8'h1C);
    end

    // Reset between E0 and F0
    send(8'h75, 1'b1, 1'b1, acc, base);
    cycles(1);
    rst_n = 1'b0;
    #2;
    chk("mid_scode", bus.scode, 8'h00);
    chk("mid_scode_en", {31'd0, bus.scode_en}, 32'd0);
    chk("mid_key_rdy", {31'd0, bus.key_rdy}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(15);
    chk("mid_cnt", pq.size() - base, 1);
    run_vec("fresh", mk(8'h3B, 1'b0, 1'b0, 1, 8'h3B, 8'h00, 8'h00));

    // Randomized back-to-back events against the reference stream
    do_reset();
    b2 = pq.size();
    exp_q.delete();
    n_ill = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        c = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hE0;
        n_ill++;
      end else begin
        c = 8'($urandom_range(0, 255));
        while (prefix(c)) c = 8'($urandom_range(0, 255));
      end
      e = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      model_push(c, e, b);
      send(c, e, b, acc, base);
    end
    cycles(12);
    chk("rnd_cnt", pq.size() - b2, exp_q.size());
    for (int i = 0; i < exp_q.size() && b2 + i < pq.size(); i++)
      chk($sformatf("rnd_byte%0d", i), pq[b2 + i], exp_q[i]);
    chk("rnd_err", err, (n_ill > 0) ? 8'h02 : 8'h00);

    chk("no_b2b", b2b_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
